// File: rtl/pulse_train_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// synth_seq_pkg
// Shared types for the pulse-train sequencer that sits in front of the DDS core.
//   seq_state_t : sequencer FSM states (IDLE, PULSE, GAP)
//   SIG_*       : SIGNAL_TYPE encodings understood by the DDS core
// -----------------------------------------------------------------------------
package synth_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  localparam logic [1:0] SIG_LFM   = 2'd1;
  localparam logic [1:0] SIG_PSK   = 2'd2;
  localparam logic [1:0] SIG_NOISE = 2'd3;

endpackage

// File: rtl/pulse_train_sequencer_us_prescaler.sv
// -----------------------------------------------------------------------------
// us_prescaler
// Divides the system clock down to a one-microsecond tick.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_clear   : restart the microsecond from count 0 on the next cycle
//   o_us_tick : high for one cycle on the last clock of each microsecond
// -----------------------------------------------------------------------------
module us_prescaler #(
  parameter int CLK_PER_US = 500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_us_tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_us_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_us_tick = (r_cnt == LAST);

endmodule

// File: rtl/pulse_train_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_train_sequencer
// Turns microsecond pulse-width / period / count settings into a cycle-exact
// GATE for the DDS core, strobes PULSE_START on the first cycle of every pulse
// and holds a shadow copy of the waveform configuration for the whole burst.
//
// Inputs : CLK, RESET (async, active low), SIGN_START_GEN (rising edge starts
//          a burst), STOP (level abort), SIGNAL_TYPE, F_CARRIER, T_IMPULSE,
//          T_PERIOD, NUM_OF_IMP (0 = continuous), DEVIATION
// Outputs: GATE, PULSE_START, CFG_TYPE/CFG_FREQ/CFG_DEV, BUSY, DONE, CFG_ERR,
//          DBG_STATE (current FSM state),
//          PULSE_IDX (only when SEQ_PULSE_INDEX_EN is defined)
//
// Build option: SEQ_PULSE_INDEX_EN adds PULSE_IDX, the 0-based index of the
// current/last pulse, updated together with PULSE_START.
//
// Every output is a flop, so an asynchronous RESET clears them all at once.
// -----------------------------------------------------------------------------
module pulse_train_sequencer
  import synth_seq_pkg::*;
#(
  parameter int CLK_PER_US = 500,
  parameter int TIMP_W     = 10,
  parameter int TPER_W     = 13,
  parameter int NIMP_W     = 5,
  parameter int TYPE_W     = 2,
  parameter int FREQ_W     = 32,
  parameter int DEV_W      = 22
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SIGN_START_GEN,
  input  logic              STOP,
  input  logic [TYPE_W-1:0] SIGNAL_TYPE,
  input  logic [FREQ_W-1:0] F_CARRIER,
  input  logic [TIMP_W-1:0] T_IMPULSE,
  input  logic [TPER_W-1:0] T_PERIOD,
  input  logic [NIMP_W-1:0] NUM_OF_IMP,
  input  logic [DEV_W-1:0]  DEVIATION,
  output logic              GATE,
  output logic              PULSE_START,
  output logic [TYPE_W-1:0] CFG_TYPE,
  output logic [FREQ_W-1:0] CFG_FREQ,
  output logic [DEV_W-1:0]  CFG_DEV,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_ERR,
`ifdef SEQ_PULSE_INDEX_EN
  output logic [NIMP_W-1:0] PULSE_IDX,
`endif
  output seq_state_t        DBG_STATE
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;

  logic              r_start_d;
  logic [TIMP_W-1:0] r_timp;
  logic [TPER_W-1:0] r_gap_us;
  logic [NIMP_W-1:0] r_num;
  logic [NIMP_W-1:0] r_pulse_cnt;
  logic [TPER_W-1:0] r_us_cnt;
  logic [TYPE_W-1:0] r_cfg_type;
  logic [FREQ_W-1:0] r_cfg_freq;
  logic [DEV_W-1:0]  r_cfg_dev;
  logic              r_gate, r_pulse_start, r_busy, r_done, r_cfg_err;

  logic w_rise, w_cfg_bad, w_start_ok, w_us_tick, w_clear;
  logic w_pulse_end, w_gap_end, w_last;
  logic w_gate_nxt, w_ps_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

  // Edge detector register resets high so a start level held through reset
  // is not mistaken for a new request.
  assign w_rise     = SIGN_START_GEN & ~r_start_d;
  assign w_cfg_bad  = (T_IMPULSE == '0) || (T_PERIOD <= TPER_W'(T_IMPULSE));
  assign w_start_ok = (r_state == ST_IDLE) && w_rise && !STOP && !w_cfg_bad;

  // Prescaler and us counter restart on every state change so each phase is
  // timed from zero.
  assign w_clear = (w_next_state != r_state);

  us_prescaler #(.CLK_PER_US(CLK_PER_US)) u_prescaler (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_clear   (w_clear),
    .o_us_tick (w_us_tick)
  );

  // r_timp >= 1 and r_gap_us >= 1 are guaranteed by start validation.
  assign w_pulse_end = w_us_tick && (r_us_cnt == TPER_W'(r_timp) - TPER_W'(1));
  assign w_gap_end   = w_us_tick && (r_us_cnt == r_gap_us - TPER_W'(1));
  assign w_last      = (r_num != '0) && (r_pulse_cnt == r_num);

  // ---- FSM: state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // ---- FSM: next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok) w_next_state = ST_PULSE;
      ST_PULSE: begin
        if (STOP)             w_next_state = ST_IDLE;
        else if (w_pulse_end) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        if (STOP)           w_next_state = ST_IDLE;
        else if (w_gap_end) w_next_state = w_last ? ST_IDLE : ST_PULSE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs (computed from the next state, then registered)
  always_comb begin
    w_gate_nxt = (w_next_state == ST_PULSE);
    w_busy_nxt = (w_next_state != ST_IDLE);
    w_ps_nxt   = (w_next_state == ST_PULSE) && (r_state != ST_PULSE);
    w_done_nxt = (r_state == ST_GAP) && (w_next_state == ST_IDLE) && !STOP;
    w_err_nxt  = (r_state == ST_IDLE) && w_rise && !STOP && w_cfg_bad;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_gate        <= 1'b0;
      r_pulse_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_gate        <= w_gate_nxt;
      r_pulse_start <= w_ps_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_cfg_err     <= w_err_nxt;
    end
  end

  // ---- start edge, shadow config, counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_start_d   <= 1'b1;
      r_timp      <= '0;
      r_gap_us    <= '0;
      r_num       <= '0;
      r_cfg_type  <= '0;
      r_cfg_freq  <= '0;
      r_cfg_dev   <= '0;
      r_pulse_cnt <= '0;
      r_us_cnt    <= '0;
    end else begin
      r_start_d <= SIGN_START_GEN;
      if (w_start_ok) begin
        r_timp     <= T_IMPULSE;
        r_gap_us   <= T_PERIOD - TPER_W'(T_IMPULSE);
        r_num      <= NUM_OF_IMP;
        r_cfg_type <= SIGNAL_TYPE;
        r_cfg_freq <= F_CARRIER;
        r_cfg_dev  <= DEVIATION;
      end
      // Counts pulses started in this burst; wraps freely in continuous mode.
      if (w_ps_nxt) begin
        r_pulse_cnt <= (r_state == ST_IDLE) ? NIMP_W'(1) : r_pulse_cnt + NIMP_W'(1);
      end
      if (w_clear)        r_us_cnt <= '0;
      else if (w_us_tick) r_us_cnt <= r_us_cnt + TPER_W'(1);
    end
  end

`ifdef SEQ_PULSE_INDEX_EN
  logic [NIMP_W-1:0] r_pulse_idx;

  // Index of the pulse now starting equals the count of pulses before it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pulse_idx <= '0;
    end else if (w_ps_nxt) begin
      r_pulse_idx <= (r_state == ST_IDLE) ? '0 : r_pulse_cnt;
    end
  end

  assign PULSE_IDX = r_pulse_idx;
`endif

  assign GATE        = r_gate;
  assign PULSE_START = r_pulse_start;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign CFG_ERR     = r_cfg_err;
  assign CFG_TYPE    = r_cfg_type;
  assign CFG_FREQ    = r_cfg_freq;
  assign CFG_DEV     = r_cfg_dev;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_sequencer
// Directed bench for pulse_train_sequencer with CLK_PER_US = 4.
// Inputs change and outputs are sampled on the falling clock edge.
// Define SEQ_PULSE_INDEX_EN to also exercise PULSE_IDX.
// -----------------------------------------------------------------------------
module tb_pulse_train_sequencer;
  import synth_seq_pkg::*;

  localparam int CPU = 4;

  logic        clk;
  logic        rst_n;
  logic        sign_start;
  logic        stop;
  logic [1:0]  signal_type;
  logic [31:0] f_carrier;
  logic [9:0]  t_impulse;
  logic [12:0] t_period;
  logic [4:0]  num_of_imp;
  logic [21:0] deviation;
  logic        gate, pulse_start, busy, done, cfg_err;
  logic [1:0]  cfg_type;
  logic [31:0] cfg_freq;
  logic [21:0] cfg_dev;
  seq_state_t  dbg_state;
`ifdef SEQ_PULSE_INDEX_EN
  logic [4:0]  pulse_idx;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pulse_train_sequencer #(.CLK_PER_US(CPU)) dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .SIGN_START_GEN (sign_start),
    .STOP           (stop),
    .SIGNAL_TYPE    (signal_type),
    .F_CARRIER      (f_carrier),
    .T_IMPULSE      (t_impulse),
    .T_PERIOD       (t_period),
    .NUM_OF_IMP     (num_of_imp),
    .DEVIATION      (deviation),
    .GATE           (gate),
    .PULSE_START    (pulse_start),
    .CFG_TYPE       (cfg_type),
    .CFG_FREQ       (cfg_freq),
    .CFG_DEV        (cfg_dev),
    .BUSY           (busy),
    .DONE           (done),
    .CFG_ERR        (cfg_err),
`ifdef SEQ_PULSE_INDEX_EN
    .PULSE_IDX      (pulse_idx),
`endif
    .DBG_STATE      (dbg_state)
  );

  // ---- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- drivers
  task automatic set_cfg(input logic [1:0] ty, input logic [31:0] fr, input logic [21:0] dv,
                         input logic [9:0] ti, input logic [12:0] tp, input logic [4:0] n);
    signal_type = ty;
    f_carrier   = fr;
    deviation   = dv;
    t_impulse   = ti;
    t_period    = tp;
    num_of_imp  = n;
  endtask

  // Produces a low->high edge; returns on the first cycle after the sampled edge.
  task automatic start_rise();
    sign_start = 1'b0;
    @(negedge clk);
    sign_start = 1'b1;
    @(negedge clk);
  endtask

  // ---- directed sequence
  initial begin
    rst_n = 1'b0;
    sign_start = 1'b0;
    stop = 1'b0;
    set_cfg(2'd0, 32'd0, 22'd0, 10'd0, 13'd0, 5'd0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_gate", gate, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ps", pulse_start, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_freq", cfg_freq, 32'd0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    // 1: T_IMP=3 us, T_PER=5 us, 2 pulses -> 12 high / 8 low x2, DONE at cycle 40
    set_cfg(SIG_PSK, 32'h0100_0000, 22'h1_0000, 10'd3, 13'd5, 5'd2);
    start_rise();
    for (int i = 0; i < 42; i++) begin
      chk($sformatf("t1_gate[%0d]", i), gate, (i < 40) && ((i % 20) < 12));
      chk($sformatf("t1_busy[%0d]", i), busy, i < 40);
      chk($sformatf("t1_ps[%0d]", i), pulse_start, (i == 0) || (i == 20));
      chk($sformatf("t1_done[%0d]", i), done, i == 40);
      @(negedge clk);
    end
    chk("t1_cfg_type", cfg_type, SIG_PSK);
    chk("t1_cfg_freq", cfg_freq, 32'h0100_0000);
    chk("t1_cfg_dev", cfg_dev, 22'h1_0000);

    // 2: rejected starts (T_PER == T_IMP, then T_IMP == 0)
    set_cfg(SIG_NOISE, 32'h5555_5555, 22'h3_FFFF, 10'd3, 13'd3, 5'd1);
    start_rise();
    chk("t2_err", cfg_err, 1'b1);
    chk("t2_gate", gate, 1'b0);
    chk("t2_busy", busy, 1'b0);
    @(negedge clk);
    chk("t2_err_1cyc", cfg_err, 1'b0);
    chk("t2_busy_later", busy, 1'b0);
    chk("t2_cfg_type", cfg_type, SIG_PSK);
    chk("t2_cfg_freq", cfg_freq, 32'h0100_0000);
    chk("t2_cfg_dev", cfg_dev, 22'h1_0000);
    t_impulse = 10'd0;
    t_period  = 13'd4;
    start_rise();
    chk("t2_err_timp0", cfg_err, 1'b1);
    chk("t2_busy_timp0", busy, 1'b0);
    @(negedge clk);
    chk("t2_err_timp0_1cyc", cfg_err, 1'b0);

    // STOP coincident with a rise: no start, and no CFG_ERR even for a bad config
    set_cfg(SIG_LFM, 32'h0000_00AA, 22'h0_00BB, 10'd1, 13'd1, 5'd0);
    sign_start = 1'b0;
    @(negedge clk);
    sign_start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    chk("stop_rise_err", cfg_err, 1'b0);
    chk("stop_rise_busy", busy, 1'b0);
    stop = 1'b0;
    @(negedge clk);
    chk("stop_rise_busy2", busy, 1'b0);
    chk("stop_rise_err2", cfg_err, 1'b0);

    // 3: continuous, 1 us / 2 us -> 4 high / 4 low, STOP mid-pulse of period 6
    set_cfg(SIG_LFM, 32'h0000_1000, 22'h0_0200, 10'd1, 13'd2, 5'd0);
    start_rise();
    for (int i = 0; i < 42; i++) begin
      chk($sformatf("t3_gate[%0d]", i), gate, (i % 8) < 4);
      chk($sformatf("t3_busy[%0d]", i), busy, 1'b1);
      chk($sformatf("t3_ps[%0d]", i), pulse_start, (i % 8) == 0);
      chk($sformatf("t3_done[%0d]", i), done, 1'b0);
      if (i < 41) @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    chk("t3_stop_gate", gate, 1'b0);
    chk("t3_stop_busy", busy, 1'b0);
    chk("t3_stop_done", done, 1'b0);
    chk("t3_stop_state", dbg_state, ST_IDLE);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_after_done[%0d]", i), done, 1'b0);
      chk($sformatf("t3_after_busy[%0d]", i), busy, 1'b0);
    end

    // 4: new rise and changed inputs while BUSY are ignored
    set_cfg(SIG_LFM, 32'h1234_5678, 22'h2_AAAA, 10'd3, 13'd5, 5'd2);
    start_rise();
    for (int i = 0; i < 42; i++) begin
      chk($sformatf("t4_gate[%0d]", i), gate, (i < 40) && ((i % 20) < 12));
      chk($sformatf("t4_busy[%0d]", i), busy, i < 40);
      chk($sformatf("t4_ps[%0d]", i), pulse_start, (i == 0) || (i == 20));
      chk($sformatf("t4_done[%0d]", i), done, i == 40);
      chk($sformatf("t4_cfg_type[%0d]", i), cfg_type, SIG_LFM);
      chk($sformatf("t4_cfg_freq[%0d]", i), cfg_freq, 32'h1234_5678);
      chk($sformatf("t4_cfg_dev[%0d]", i), cfg_dev, 22'h2_AAAA);
      if (i == 4) sign_start = 1'b0;
      if (i == 6) begin
        sign_start = 1'b1;
        set_cfg(SIG_NOISE, 32'hDEAD_BEEF, 22'h1_2345, 10'd1, 13'd2, 5'd0);
      end
      @(negedge clk);
    end

    // 5: async reset mid-pulse, start level held through reset
    start_rise();
    @(negedge clk);
    chk("t5_gate_before", gate, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gate", gate, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_freq", cfg_freq, 32'd0);
    chk("t5_async_type", cfg_type, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_held_busy[%0d]", i), busy, 1'b0);
      chk($sformatf("t5_held_gate[%0d]", i), gate, 1'b0);
    end
    start_rise();
    chk("t5_restart_gate", gate, 1'b1);
    chk("t5_restart_busy", busy, 1'b1);
    chk("t5_restart_ps", pulse_start, 1'b1);
    chk("t5_restart_freq", cfg_freq, 32'hDEAD_BEEF);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("t5_stopped", busy, 1'b0);

`ifdef SEQ_PULSE_INDEX_EN
    // 6: PULSE_IDX steps 0,1,2 with PULSE_START
    set_cfg(SIG_PSK, 32'h0000_0777, 22'h0_0111, 10'd1, 13'd2, 5'd3);
    start_rise();
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("t6_ps[%0d]", i), pulse_start, (i < 24) && ((i % 8) == 0));
      chk($sformatf("t6_idx[%0d]", i), pulse_idx, (i < 24) ? (i / 8) : 2);
      chk($sformatf("t6_done[%0d]", i), done, i == 24);
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
